// File: rtl/dual_read_burst_scheduler.sv
// Round-robin SDRAM read-burst scheduler that keeps two display FIFOs topped up and tracks
// per-camera frame addresses, rewinding both channels on every frame start.
module dual_read_burst_scheduler #(
  parameter int                ADDR_W      = 24,
  parameter int                LEN_W       = 9,
  parameter int                BURST_LEN   = 256,
  parameter int                LOW_WM      = 512,
  parameter int                FRAME_WORDS = 307200,
  parameter logic [ADDR_W-1:0] BASE0       = '0,
  parameter logic [ADDR_W-1:0] BASE1       = ADDR_W'(24'h080000),
  parameter int                FLUSH_CYC   = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_frame_start,
  input  logic [10:0]       i_fifo_used0,
  input  logic [10:0]       i_fifo_used1,
  output logic              o_burst_req,
  output logic              o_burst_ch,
  output logic [ADDR_W-1:0] o_burst_addr,
  output logic [LEN_W-1:0]  o_burst_len,
  input  logic              i_burst_ack,
  input  logic              i_burst_done,
  output logic [1:0]        o_fifo_clr,
  output logic [1:0]        o_frame_done,
  output logic              o_busy
);

  localparam int WORDS_W = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W   = $clog2(FLUSH_CYC + 1);

  localparam logic [ADDR_W-1:0]  BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [WORDS_W-1:0] BURST_W = WORDS_W'(BURST_LEN);
  localparam logic [WORDS_W-1:0] FRAME_W = WORDS_W'(FRAME_WORDS);
  localparam logic [10:0]        LOW_V   = 11'(LOW_WM);
  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q  [2];
  logic [ADDR_W-1:0]  addr_d  [2];
  logic [WORDS_W-1:0] words_q [2];
  logic [WORDS_W-1:0] words_d [2];
  logic               rr_q, rr_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               ch_q, ch_d;
  logic [ADDR_W-1:0]  baddr_q, baddr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         clr_q, clr_d;
  logic [1:0]         fdone_q, fdone_d;
  logic [1:0]         need;
  logic               grant;
  logic               enter_flush;

  assign need[0] = (i_fifo_used0 < LOW_V) && !fdone_q[0] && !pend_q;
  assign need[1] = (i_fifo_used1 < LOW_V) && !fdone_q[1] && !pend_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    words_d     = words_q;
    rr_d        = rr_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    ch_d        = ch_q;
    baddr_d     = baddr_q;
    len_d       = len_q;
    clr_d       = 2'b00;
    fdone_d     = fdone_q;
    grant       = 1'b0;
    enter_flush = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          enter_flush = 1'b1;
        end else if (|need) begin
          // Tie goes to the channel that was not granted last.
          grant   = (need == 2'b11) ? ~rr_q : need[1];
          rr_d    = grant;
          req_d   = 1'b1;
          ch_d    = grant;
          baddr_d = addr_q[grant];
          len_d   = LEN_W'(BURST_LEN);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_frame_start) pend_d = 1'b1;
        if (i_burst_ack) begin
          req_d   = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_frame_start) pend_d = 1'b1;
        if (i_burst_done) begin
          addr_d[ch_q]  = addr_q[ch_q] + BURST_A;
          words_d[ch_q] = words_q[ch_q] + BURST_W;
          if (words_d[ch_q] == FRAME_W) fdone_d[ch_q] = 1'b1;
          if (pend_q || i_frame_start) enter_flush = 1'b1;
          else                         state_d     = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (i_frame_start)   cnt_d   = CNT_TOP;
        else if (cnt_q == '0) state_d = S_IDLE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Rewind overrides any bookkeeping from a burst finishing in the same cycle.
    if (enter_flush) begin
      state_d    = S_FLUSH;
      clr_d      = 2'b11;
      addr_d[0]  = BASE0;
      addr_d[1]  = BASE1;
      words_d[0] = '0;
      words_d[1] = '0;
      fdone_d    = 2'b00;
      pend_d     = 1'b0;
      cnt_d      = CNT_TOP;
    end
  end

  // NOTE: the address/word arrays sit in flops, not RAM, so they take the async reset like any register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= S_IDLE;
      addr_q[0]  <= BASE0;
      addr_q[1]  <= BASE1;
      words_q[0] <= '0;
      words_q[1] <= '0;
      rr_q       <= 1'b1;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      ch_q       <= 1'b0;
      baddr_q    <= '0;
      len_q      <= '0;
      clr_q      <= 2'b00;
      fdone_q    <= 2'b00;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ch_q    <= ch_d;
      baddr_q <= baddr_d;
      len_q   <= len_d;
      clr_q   <= clr_d;
      fdone_q <= fdone_d;
    end
  end

  assign o_burst_req  = req_q;
  assign o_burst_ch   = ch_q;
  assign o_burst_addr = baddr_q;
  assign o_burst_len  = len_q;
  assign o_fifo_clr   = clr_q;
  assign o_frame_done = fdone_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
